// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file BIST sequencer: default geometry,
// FSM state encoding and the test pattern generator.
package regfile_pkg;

    localparam int          DEF_ADDR_W   = 5;
    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_NUM_REGS = 32;
    localparam logic [31:0] DEF_SEED     = 32'h8000_1111;
    localparam logic [31:0] DEF_STRIDE   = 32'h0000_0001;
    localparam int          DEF_ERR_W    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    // Value written to register i; wraps modulo 2**DEF_DATA_W.
    function automatic logic [DEF_DATA_W-1:0] pattern(
        input int unsigned           i,
        input logic [DEF_DATA_W-1:0] seed,
        input logic [DEF_DATA_W-1:0] stride
    );
        return seed + DEF_DATA_W'(i) * stride;
    endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// Two-port read-back comparator with a saturating mismatch counter and a
// first-mismatch address latch (port A wins a same-cycle tie).
module regfile_bist_cmp
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ERR_W  = DEF_ERR_W
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_exp_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic [DATA_W-1:0] i_exp_b,
    output logic [ADDR_W-1:0] o_err_addr,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [ERR_W-1:0]  o_count_next
);

    logic [ERR_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_err_addr;
    logic              w_miss_a;
    logic              w_miss_b;
    logic [ERR_W:0]    w_sum;
    logic [ERR_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] w_err_addr_next;

    assign w_miss_a = i_en && (i_data_a != i_exp_a);
    assign w_miss_b = i_en && (i_data_b != i_exp_b);
    assign w_sum    = {1'b0, r_count} + {{ERR_W{1'b0}}, w_miss_a} + {{ERR_W{1'b0}}, w_miss_b};

    always_comb begin
        w_count_next    = r_count;
        w_err_addr_next = r_err_addr;
        if (i_clear) begin
            w_count_next    = '0;
            w_err_addr_next = '0;
        end else begin
            // Carry out of the add can only mean we passed the maximum.
            w_count_next = w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];
            if (r_count == '0) begin
                if (w_miss_a) begin
                    w_err_addr_next = i_addr_a;
                end else if (w_miss_b) begin
                    w_err_addr_next = i_addr_b;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count    <= '0;
            r_err_addr <= '0;
        end else begin
            r_count    <= w_count_next;
            r_err_addr <= w_err_addr_next;
        end
    end

    assign o_err_addr   = r_err_addr;
    assign o_err_count  = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST sequencer: writes a linear pattern, reads it back on both
// ports in opposite orders and reports the result. REGFILE_ZERO_REG_EN treats
// register 0 as hardwired zero (not written, expected to read 0).
module regfile_bist
    import regfile_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter logic [DATA_W-1:0] SEED     = DATA_W'(DEF_SEED),
    parameter logic [DATA_W-1:0] STRIDE   = DATA_W'(DEF_STRIDE),
    parameter int                ERR_W    = DEF_ERR_W
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ADDR_W-1:0] Err_Addr,
    output logic [ERR_W-1:0]  Err_Count,
    output logic [7:0]        LED
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
`ifdef REGFILE_ZERO_REG_EN
    localparam logic [ADDR_W-1:0] FIRST_W = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_W = '0;
`endif

    function automatic logic [DATA_W-1:0] f_pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(pattern(32'(a), DEF_DATA_W'(SEED), DEF_DATA_W'(STRIDE)));
    endfunction

    function automatic logic [DATA_W-1:0] f_expect(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == '0) begin
            return '0;
        end
`endif
        return f_pat(a);
    endfunction

    bist_state_t       r_state;
    bist_state_t       w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;
    logic [ADDR_W-1:0] w_idx_inc;

    logic              r_write;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_raddr_a;
    logic [ADDR_W-1:0] r_raddr_b;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_write_next;
    logic [ADDR_W-1:0] w_waddr_next;
    logic [DATA_W-1:0] w_wdata_next;
    logic [ADDR_W-1:0] w_raddr_a_next;
    logic [ADDR_W-1:0] w_raddr_b_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_pass_next;
    logic              w_cmp_en;
    logic              w_clear;
    logic [ERR_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] w_err_addr;
    logic [ERR_W-1:0]  w_err_count;

    assign w_idx_inc = r_idx + ADDR_W'(1);
    assign w_cmp_en  = (r_state == READ);

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_write_next   = 1'b0;
        w_waddr_next   = '0;
        w_wdata_next   = '0;
        w_raddr_a_next = '0;
        w_raddr_b_next = '0;
        w_busy_next    = 1'b0;
        w_done_next    = r_done;
        w_pass_next    = r_pass;
        w_clear        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_state_next = WRITE;
                    w_idx_next   = FIRST_W;
                    w_write_next = 1'b1;
                    w_waddr_next = FIRST_W;
                    w_wdata_next = f_pat(FIRST_W);
                    w_busy_next  = 1'b1;
                    w_done_next  = 1'b0;
                    w_pass_next  = 1'b0;
                    w_clear      = 1'b1;
                end
            end
            WRITE: begin
                w_busy_next = 1'b1;
                if (r_idx == LAST) begin
                    w_state_next   = READ;
                    w_idx_next     = '0;
                    w_raddr_a_next = '0;
                    w_raddr_b_next = LAST;
                end else begin
                    w_idx_next   = w_idx_inc;
                    w_write_next = 1'b1;
                    w_waddr_next = w_idx_inc;
                    w_wdata_next = f_pat(w_idx_inc);
                end
            end
            READ: begin
                if (r_idx == LAST) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                    // Pass must include the comparison made on this final edge.
                    w_pass_next  = (w_cnt_next == '0);
                end else begin
                    w_busy_next    = 1'b1;
                    w_idx_next     = w_idx_inc;
                    w_raddr_a_next = w_idx_inc;
                    w_raddr_b_next = LAST - w_idx_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_write   <= w_write_next;
            r_waddr   <= w_waddr_next;
            r_wdata   <= w_wdata_next;
            r_raddr_a <= w_raddr_a_next;
            r_raddr_b <= w_raddr_b_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_pass    <= w_pass_next;
        end
    end

    regfile_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_cmp (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_clear      (w_clear),
        .i_en         (w_cmp_en),
        .i_addr_a     (r_raddr_a),
        .i_addr_b     (r_raddr_b),
        .i_data_a     (R_Data_A),
        .i_exp_a      (f_expect(r_raddr_a)),
        .i_data_b     (R_Data_B),
        .i_exp_b      (f_expect(r_raddr_b)),
        .o_err_addr   (w_err_addr),
        .o_err_count  (w_err_count),
        .o_count_next (w_cnt_next)
    );

    assign Write_Reg = r_write;
    assign W_Addr    = r_waddr;
    assign W_Data    = r_wdata;
    assign R_Addr_A  = r_raddr_a;
    assign R_Addr_B  = r_raddr_b;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Pass      = r_pass;
    assign Err_Addr  = w_err_addr;
    assign Err_Count = w_err_count;
    assign LED       = {r_pass, r_done, r_busy, w_err_addr[4:0]};

endmodule
